cpu_sequencer: RTL

//  Multi-cycle fetch/decode/execute controller for the 8-bit accumulator CPU.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/cpu_sequencer_if.sv | 27 ++
 rtl/wait_timer.sv | 32 +++
 rtl/cpu_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, state encoding and control codes for the sequencer
//
// Purpose: opcode values, FSM state encoding and ACC/ALU operation codes used by
//          the sequencer decode logic and by its bench.
// Ports:   none (package).
package cpu_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ACC1  = 8'h01;
  localparam logic [7:0] OP_ACC2  = 8'h02;
  localparam logic [7:0] OP_ACC3  = 8'h03;
  localparam logic [7:0] OP_ACC4  = 8'h04;
  localparam logic [7:0] OP_ADD   = 8'h05;
  localparam logic [7:0] OP_STORE = 8'h06;
  localparam logic [7:0] OP_LOAD  = 8'h07;
  localparam logic [7:0] OP_JMP   = 8'h08;
  localparam logic [7:0] OP_BRN   = 8'h09;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [1:0] ACCOP_U0 = 2'd0;
  localparam logic [1:0] ACCOP_U1 = 2'd1;
  localparam logic [1:0] ACCOP_U2 = 2'd2;
  localparam logic [1:0] ACCOP_U3 = 2'd3;

  localparam logic [2:0] ALUOP_ADD = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERR
  } state_t;

  // Unary ACC opcodes 01..04 map onto accop 0..3.
  function automatic logic [1:0] accop_of(input logic [7:0] opc);
    case (opc)
      OP_ACC2: accop_of = ACCOP_U1;
      OP_ACC3: accop_of = ACCOP_U2;
      OP_ACC4: accop_of = ACCOP_U3;
      default: accop_of = ACCOP_U0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - instruction/data memory handshake bundle
//
// Purpose: groups the fetch and data-memory request/ready signals.
// Signals: imem_rd (fetch request), imem_rdy/ins_in (fetch reply),
//          dmem_rd/dmem_wr/dmem_addr (data request), dmem_rdy (data reply).
// Modports: master = sequencer side, slave = memory side.
interface cpu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            imem_rd;
  logic            imem_rdy;
  logic [15:0]     ins_in;
  logic            dmem_rd;
  logic            dmem_wr;
  logic            dmem_rdy;
  logic [PC_W-1:0] dmem_addr;

  modport master (
    output imem_rd, dmem_rd, dmem_wr, dmem_addr,
    input  imem_rdy, ins_in, dmem_rdy
  );

  modport slave (
    input  imem_rd, dmem_rd, dmem_wr, dmem_addr,
    output imem_rdy, ins_in, dmem_rdy
  );
endinterface

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - bounded wait counter for memory handshakes
//
// Purpose: counts cycles spent waiting for a ready; o_expired is high in the
//          TIMEOUT-th wait cycle after the last clear.
// Ports:   i_clk, i_rst_n (sync active-low), i_clear (restart count),
//          i_enable (count this cycle), o_expired (final wait cycle reached).
module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the number of completed wait cycles, so the count equals
  // TIMEOUT-1 during the TIMEOUT-th cycle of waiting.
  assign o_expired = (r_count == LAST);
endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute controller
//
// Purpose: sequences instruction fetch, decode, data access and write-back for
//          the 8-bit accumulator CPU, tolerating variable memory latency.
// Ports:   i_clk, i_rst_n (sync active-low), i_run (start/continue level),
//          i_acc_msb (ACC sign for BRN), mem (memory handshakes, master),
//          o_ir_load, o_pc_inc, o_pc_load, o_pc_target, o_acc_ena, o_accop,
//          o_aluop, o_alu_sel (datapath strobes), o_busy, o_halted,
//          o_illegal (sticky), o_err (sticky).
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_run,
  input  logic            i_acc_msb,
  cpu_sequencer_if.master mem,
  output logic            o_ir_load,
  output logic            o_pc_inc,
  output logic            o_pc_load,
  output logic [PC_W-1:0] o_pc_target,
  output logic            o_acc_ena,
  output logic [1:0]      o_accop,
  output logic [2:0]      o_aluop,
  output logic            o_alu_sel,
  output logic            o_busy,
  output logic            o_halted,
  output logic            o_illegal,
  output logic            o_err
);
  state_t      r_state;
  logic [15:0] r_ir;
  logic        r_imem_rd, r_dmem_rd, r_dmem_wr;
  logic        r_ir_load, r_pc_inc, r_pc_load, r_acc_ena, r_alu_sel;
  logic [1:0]  r_accop;
  logic [2:0]  r_aluop;
  logic        r_busy, r_halted, r_illegal, r_err;

  logic [7:0]  w_opc;
  logic [7:0]  w_ir_opc;
  logic        w_waiting;
  logic        w_rdy;
  logic        w_expired;

  assign w_opc     = mem.ins_in[15:8];
  assign w_ir_opc  = r_ir[15:8];
  assign w_waiting = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_rdy     = (r_state == ST_FETCH) ? mem.imem_rdy : mem.dmem_rdy;

  // Clearing whenever a wait completes (not only outside wait states) keeps
  // the count fresh for a STORE that retires straight from MEM into FETCH.
  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (!w_waiting || w_rdy),
    .i_enable  (w_waiting),
    .o_expired (w_expired)
  );

  // Every output is registered on the edge that enters the cycle it belongs
  // to: DECODE strobes are decoded from ins_in on the fetch-ready edge so they
  // coincide with the DECODE cycle, WB strobes are set on the MEM-ready edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_ir      <= '0;
      r_imem_rd <= 1'b0;
      r_dmem_rd <= 1'b0;
      r_dmem_wr <= 1'b0;
      r_ir_load <= 1'b0;
      r_pc_inc  <= 1'b0;
      r_pc_load <= 1'b0;
      r_acc_ena <= 1'b0;
      r_accop   <= ACCOP_U0;
      r_aluop   <= ALUOP_ADD;
      r_alu_sel <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ir_load <= 1'b0;
      r_pc_inc  <= 1'b0;
      r_pc_load <= 1'b0;
      r_acc_ena <= 1'b0;
      r_accop   <= ACCOP_U0;
      r_aluop   <= ALUOP_ADD;
      r_alu_sel <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_run) begin
            r_state   <= ST_FETCH;
            r_imem_rd <= 1'b1;
            r_busy    <= 1'b1;
          end
        end

        ST_FETCH: begin
          // Ready wins over an expiring count in the same cycle.
          if (mem.imem_rdy) begin
            r_imem_rd <= 1'b0;
            r_ir      <= mem.ins_in;
            r_ir_load <= 1'b1;
            r_state   <= ST_DECODE;
            case (w_opc)
              OP_NOP: r_pc_inc <= 1'b1;
              OP_ACC1, OP_ACC2, OP_ACC3, OP_ACC4: begin
                r_acc_ena <= 1'b1;
                r_accop   <= accop_of(w_opc);
                r_pc_inc  <= 1'b1;
              end
              OP_ADD, OP_STORE, OP_LOAD, OP_HALT: begin
              end
              OP_JMP: r_pc_load <= 1'b1;
              OP_BRN: begin
                if (i_acc_msb) r_pc_load <= 1'b1;
                else           r_pc_inc  <= 1'b1;
              end
              default: begin
                r_illegal <= 1'b1;
                r_pc_inc  <= 1'b1;
              end
            endcase
          end else if (w_expired) begin
            r_imem_rd <= 1'b0;
            r_err     <= 1'b1;
            r_busy    <= 1'b0;
            r_halted  <= 1'b1;
            r_state   <= ST_ERR;
          end
        end

        ST_DECODE: begin
          case (w_ir_opc)
            OP_ADD, OP_LOAD: begin
              r_dmem_rd <= 1'b1;
              r_state   <= ST_MEM;
            end
            OP_STORE: begin
              r_dmem_wr <= 1'b1;
              r_state   <= ST_MEM;
            end
            OP_HALT: begin
              r_busy   <= 1'b0;
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end
            default: begin
              // Single-cycle instructions retire here.
              r_state   <= i_run ? ST_FETCH : ST_IDLE;
              r_imem_rd <= i_run;
              r_busy    <= i_run;
            end
          endcase
        end

        ST_MEM: begin
          if (mem.dmem_rdy) begin
            r_dmem_rd <= 1'b0;
            r_dmem_wr <= 1'b0;
            if (w_ir_opc == OP_STORE) begin
              r_pc_inc  <= 1'b1;
              r_state   <= i_run ? ST_FETCH : ST_IDLE;
              r_imem_rd <= i_run;
              r_busy    <= i_run;
            end else begin
              r_acc_ena <= 1'b1;
              r_pc_inc  <= 1'b1;
              r_alu_sel <= (w_ir_opc == OP_ADD);
              r_aluop   <= ALUOP_ADD;
              r_state   <= ST_WB;
            end
          end else if (w_expired) begin
            r_dmem_rd <= 1'b0;
            r_dmem_wr <= 1'b0;
            r_err     <= 1'b1;
            r_busy    <= 1'b0;
            r_halted  <= 1'b1;
            r_state   <= ST_ERR;
          end
        end

        ST_WB: begin
          r_state   <= i_run ? ST_FETCH : ST_IDLE;
          r_imem_rd <= i_run;
          r_busy    <= i_run;
        end

        ST_HALT, ST_ERR: begin
        end

        default: begin
          r_state   <= ST_IDLE;
          r_imem_rd <= 1'b0;
          r_dmem_rd <= 1'b0;
          r_dmem_wr <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign mem.imem_rd   = r_imem_rd;
  assign mem.dmem_rd   = r_dmem_rd;
  assign mem.dmem_wr   = r_dmem_wr;
  assign mem.dmem_addr = r_ir[PC_W-1:0];
  assign o_pc_target   = r_ir[PC_W-1:0];
  assign o_ir_load     = r_ir_load;
  assign o_pc_inc      = r_pc_inc;
  assign o_pc_load     = r_pc_load;
  assign o_acc_ena     = r_acc_ena;
  assign o_accop       = r_accop;
  assign o_aluop       = r_aluop;
  assign o_alu_sel     = r_alu_sel;
  assign o_busy        = r_busy;
  assign o_halted      = r_halted;
  assign o_illegal     = r_illegal;
  assign o_err         = r_err;
endmodule
